// File: rtl/pid_seq_pkg.sv
// Shared types and period helpers for the PID stage sequencer.
// Periods are clamped so a full stage walk always fits between ticks.
package pid_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    WAIT,
    SEQ
  } state_t;

  function automatic int unsigned min_period(
    input int unsigned stages
  );
    return stages + 1;
  endfunction

  function automatic int unsigned clamp_period(
    input int unsigned p,
    input int unsigned stages
  );
    int unsigned lo;
    lo = min_period(stages);
    return (p < lo) ? lo : p;
  endfunction

endpackage

// File: rtl/pid_stage_sequencer_counter.sv
// Loadable down counter that holds at zero.
// The zero flag marks the last cycle of a sample interval.
module period_counter #(
  parameter int CNT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pid_stage_sequencer.sv
// Sample-tick generator and one-hot stage-enable walker.
// Drives the clk_en / clr_n pins of the PID datapath pipeline.
module pid_stage_sequencer
  import pid_seq_pkg::*;
#(
  parameter int CNT_WIDTH      = 20,
  parameter int NUM_STAGES     = 4,
  parameter int DEFAULT_PERIOD = 500000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear_req,
  input  logic [CNT_WIDTH-1:0]  period,
  input  logic                  period_load,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  clr_n,
  output logic                  sample_tick,
  output logic                  busy
);

  state_t state;
  state_t state_nx;

  logic [CNT_WIDTH-1:0]  period_reg;
  logic [NUM_STAGES-1:0] stage_nx;
  logic                  stop_q;
  logic                  stop_nx;
  logic                  clr_nx;
  logic                  tick_nx;
  logic                  busy_nx;
  logic                  cnt_load;
  logic                  cnt_zero;
  logic                  last_stage;

  assign last_stage = stage_en[NUM_STAGES-1];

  period_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (cnt_load),
    .load_value (period_reg - CNT_WIDTH'(1)),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_reg <= CNT_WIDTH'(DEFAULT_PERIOD);
    end else if (period_load) begin
      period_reg <= CNT_WIDTH'(clamp_period(
        32'(period), NUM_STAGES));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      stop_q      <= 1'b0;
      stage_en    <= '0;
      clr_n       <= 1'b1;
      sample_tick <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      stop_q      <= stop_nx;
      stage_en    <= stage_nx;
      clr_n       <= clr_nx;
      sample_tick <= tick_nx;
      busy        <= busy_nx;
    end
  end

  // A stop request seen in SEQ is remembered so a
  // re-raised enable cannot extend the run.
  always_comb begin
    state_nx = state;
    stop_nx  = stop_q;
    unique case (state)
      IDLE: begin
        if (enable) state_nx = CLEAR;
      end
      CLEAR: begin
        state_nx = enable ? WAIT : IDLE;
      end
      WAIT: begin
        if (!enable) state_nx = IDLE;
        else if (cnt_zero) state_nx = SEQ;
      end
      SEQ: begin
        if (!enable) stop_nx = 1'b1;
        if (last_stage) begin
          state_nx = (stop_q || !enable) ? IDLE : WAIT;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (clear_req && state != IDLE) state_nx = CLEAR;
    if (state_nx == CLEAR || state_nx == IDLE) begin
      stop_nx = 1'b0;
    end
  end

  always_comb begin
    clr_nx   = 1'b1;
    tick_nx  = 1'b0;
    stage_nx = '0;
    cnt_load = 1'b0;
    busy_nx  = (state_nx != IDLE);
    if (state_nx == CLEAR) begin
      clr_nx   = 1'b0;
      cnt_load = 1'b1;
    end else if (state == IDLE && clear_req) begin
      clr_nx = 1'b0;
    end else if (state == WAIT && state_nx == SEQ) begin
      tick_nx  = 1'b1;
      stage_nx = NUM_STAGES'(1);
      cnt_load = 1'b1;
    end else if (state == SEQ && state_nx == SEQ) begin
      stage_nx = stage_en << 1;
    end
  end

endmodule

// File: tb/tb_pid_stage_sequencer.sv
// Scoreboard bench: a cycle-time model predicts every output cycle,
// a negedge monitor pops and compares against the DUT.
module tb_pid_stage_sequencer;

  localparam int NS  = 4;
  localparam int CW  = 20;
  localparam int DEF = 500000;

  typedef struct packed {
    logic          clr;
    logic          tick;
    logic [NS-1:0] stage;
    logic          busy;
  } exp_t;

  typedef enum int {M_IDLE, M_CLEAR, M_RUN} mmode_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          clear_req;
  logic [CW-1:0] period;
  logic          period_load;
  logic [NS-1:0] stage_en;
  logic          clr_n;
  logic          sample_tick;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t sb[$];

  mmode_t m_mode = M_IDLE;
  int     m_seq  = -1;
  bit     m_stop = 0;
  int     m_preg = DEF;
  int     m_next = 0;
  int     cyc    = 0;

  pid_stage_sequencer #(
    .CNT_WIDTH      (CW),
    .NUM_STAGES     (NS),
    .DEFAULT_PERIOD (DEF)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear_req   (clear_req),
    .period      (period),
    .period_load (period_load),
    .stage_en    (stage_en),
    .clr_n       (clr_n),
    .sample_tick (sample_tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t reset_exp();
    exp_t e;
    e.clr   = 1'b1;
    e.tick  = 1'b0;
    e.stage = '0;
    e.busy  = 1'b0;
    return e;
  endfunction

  // Called right after a posedge: inputs still hold the values
  // sampled by that edge; predicts outputs for the cycle now starting.
  task automatic model_step();
    exp_t e;
    int   p;
    bit   go_clear;
    cyc++;
    e = reset_exp();
    if (!reset_n) begin
      m_mode = M_IDLE;
      m_seq  = -1;
      m_stop = 0;
      m_preg = DEF;
      sb.push_back(e);
      return;
    end
    go_clear = 0;
    if (m_mode == M_IDLE) begin
      if (enable) go_clear = 1;
      else if (clear_req) e.clr = 1'b0;
    end else if (clear_req) begin
      go_clear = 1;
    end else if (m_mode == M_CLEAR) begin
      m_mode = enable ? M_RUN : M_IDLE;
    end else if (m_seq >= 0) begin
      if (!enable) m_stop = 1;
      if (m_seq == NS - 1) begin
        m_seq = -1;
        if (m_stop) m_mode = M_IDLE;
      end else begin
        m_seq++;
        e.stage = NS'(1) << m_seq;
      end
    end else if (!enable) begin
      m_mode = M_IDLE;
    end else if (cyc == m_next) begin
      e.tick  = 1'b1;
      e.stage = NS'(1);
      m_seq   = 0;
      m_next  = cyc + m_preg;
    end
    if (go_clear) begin
      m_mode = M_CLEAR;
      e.clr  = 1'b0;
      m_seq  = -1;
      m_stop = 0;
      m_next = cyc + m_preg;
    end
    if (period_load) begin
      p = int'(period);
      m_preg = (p < NS + 1) ? NS + 1 : p;
    end
    e.busy = (m_mode != M_IDLE);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    clear_req   = 1'b0;
    period_load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_seq(input int k);
    for (int i = 0; i < 60 && m_seq != k; i++) step();
    n_chk++;
    if (m_seq != k) begin
      n_fail++;
      $display("FAIL wait_seq: stage %0d not reached, at %0d", k, m_seq);
    end
  endtask

  task automatic wait_pre_tick();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      ok = (m_mode == M_RUN && m_seq < 0 && m_next == cyc + 1);
      if (!ok) step();
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_pre_tick: reached %0d required 1", ok);
    end
  endtask

  task automatic load(input int p);
    period      = CW'(p);
    period_load = 1'b1;
    step();
  endtask

  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g = {clr_n, sample_tick, stage_en, busy};
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL out cyc %0d: clr_n/tick/stage_en/busy %b %b %b %b required %b %b %b %b",
            cyc, g.clr, g.tick, g.stage, g.busy,
            e.clr, e.tick, e.stage, e.busy);
        end
      end
    end
  end

  initial begin
    exp_t g;
    reset_n     = 1'b0;
    enable      = 1'b0;
    clear_req   = 1'b0;
    period      = '0;
    period_load = 1'b0;
    run(2);
    reset_n = 1'b1;
    run(3);

    load(8);
    enable = 1'b1;
    run(32);

    load(2);
    run(25);

    load(8);
    run(4);
    wait_seq(1);
    clear_req = 1'b1;
    run(20);

    wait_pre_tick();
    clear_req = 1'b1;
    run(15);

    wait_seq(0);
    enable = 1'b0;
    run(12);
    enable = 1'b1;
    run(12);

    wait_seq(0);
    enable = 1'b0;
    step();
    enable = 1'b1;
    run(20);

    wait_seq(3);
    run(2);
    load(12);
    run(40);

    load(0);
    run(12);
    clear_req = 1'b1;
    enable    = 1'b0;
    run(4);
    clear_req = 1'b1;
    run(3);
    enable = 1'b1;
    run(10);

    wait_seq(1);
    #2;
    reset_n = 1'b0;
    #1;
    g = {clr_n, sample_tick, stage_en, busy};
    n_chk++;
    if (g !== reset_exp()) begin
      n_fail++;
      $display("FAIL async_reset: outputs %b required %b", g, reset_exp());
    end
    sb.delete();
    step();
    reset_n = 1'b1;
    run(5);
    load(6);
    run(30);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 49) == 0) clear_req = 1'b1;
      if ($urandom_range(0, 29) == 0) begin
        period      = CW'($urandom_range(0, 14));
        period_load = 1'b1;
      end
      step();
    end
    enable = 1'b0;
    run(20);
    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
